// File: rtl/logic_reduce_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : logic_reduce_stream_if
//  Description : Bundles the beat-input stream (in_data/in_valid/in_last/
//                in_ready) and the packet-result stream (out_and/out_or/
//                out_par/out_beats/out_valid/out_ready) of
//                logic_reduce_stream.
//                Modport slave  : reduction unit side.
//                Modport master : producer/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface logic_reduce_stream_if #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3,
    parameter int CNT_W  = 4
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_and;
    logic [WIDTH-1:0]        out_or;
    logic [WIDTH-1:0]        out_par;
    logic [CNT_W-1:0]        out_beats;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_and, out_or, out_par, out_beats, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_and, out_or, out_par, out_beats, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/logic_reduce_stream.sv
`default_nettype none
// ============================================================================
//  Module      : logic_reduce_stream
//  Description : Streaming AND/OR (optionally XOR parity) reduction unit.
//                Each beat carries NUM_IN words of WIDTH bits; the words are
//                reduced bitwise and accumulated over a packet delimited by
//                in_last. The packet result is held on a valid/ready output
//                until consumed; no new beat is accepted meanwhile.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - logic_reduce_stream_if.slave (beat in, result out)
//  Macro       : LOGIC_REDUCE_PARITY_EN - builds per-lane XOR parity; when
//                undefined out_par is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_reduce_stream #(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3,
    parameter int CNT_W  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    logic_reduce_stream_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_acc_and_nxt;
    logic [WIDTH-1:0] w_acc_or_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_first;

    logic [WIDTH-1:0] r_acc_and;
    logic [WIDTH-1:0] r_acc_or;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_and;
    logic [WIDTH-1:0] r_out_or;
    logic [CNT_W-1:0] r_out_beats;

    // ------------------------------------------------------------------
    // Per-beat reduction across the NUM_IN operand words
    // ------------------------------------------------------------------
    always_comb begin
        w_and = bus.in_data[WIDTH-1:0];
        w_or  = bus.in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            w_and = w_and & bus.in_data[k*WIDTH +: WIDTH];
            w_or  = w_or  | bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign w_in_ready = (r_state != S_HOLD);
    assign w_accept   = bus.in_valid && w_in_ready;
    // In IDLE the incoming beat starts a fresh packet, so stale
    // accumulator contents are overwritten rather than merged.
    assign w_first    = (r_state == S_IDLE);

    assign w_acc_and_nxt = w_first ? w_and : (r_acc_and & w_and);
    assign w_acc_or_nxt  = w_first ? w_or  : (r_acc_or  | w_or);
    assign w_cnt_nxt     = w_first              ? c_CNT_ONE :
                           (r_cnt == c_CNT_MAX) ? r_cnt     :
                                                  (r_cnt + c_CNT_ONE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_state_nxt = bus.in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulators and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_and   <= '0;
            r_acc_or    <= '0;
            r_cnt       <= '0;
            r_out_and   <= '0;
            r_out_or    <= '0;
            r_out_beats <= '0;
        end else if (w_accept) begin
            r_acc_and <= w_acc_and_nxt;
            r_acc_or  <= w_acc_or_nxt;
            r_cnt     <= w_cnt_nxt;
            // Result captures the post-update values on the closing beat.
            if (bus.in_last) begin
                r_out_and   <= w_acc_and_nxt;
                r_out_or    <= w_acc_or_nxt;
                r_out_beats <= w_cnt_nxt;
            end
        end
    end

`ifdef LOGIC_REDUCE_PARITY_EN
    logic [WIDTH-1:0] w_par;
    logic [WIDTH-1:0] w_acc_par_nxt;
    logic [WIDTH-1:0] r_acc_par;
    logic [WIDTH-1:0] r_out_par;

    always_comb begin
        w_par = bus.in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            w_par = w_par ^ bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign w_acc_par_nxt = w_first ? w_par : (r_acc_par ^ w_par);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_par <= '0;
            r_out_par <= '0;
        end else if (w_accept) begin
            r_acc_par <= w_acc_par_nxt;
            if (bus.in_last) begin
                r_out_par <= w_acc_par_nxt;
            end
        end
    end

    assign bus.out_par = r_out_par;
`else
    assign bus.out_par = '0;
`endif

    // HOLD is exactly the "result pending" condition, so the state
    // register doubles as the registered out_valid flag.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_and   = r_out_and;
    assign bus.out_or    = r_out_or;
    assign bus.out_beats = r_out_beats;

endmodule
`default_nettype wire
